// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller:
// refill FSM states and the ALU operand forwarding select encodings.
package mips_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2,
    REFILL    = 2'd3
  } state_e;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // The younger result (EX_MEM) shadows the older one (MEM_WB); $zero is never forwarded.
  function automatic logic [1:0] fwd_select(input logic       ex_we,
                                            input logic [4:0] ex_rd,
                                            input logic       wb_we,
                                            input logic [4:0] wb_rd,
                                            input logic [4:0] src);
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex_we && (ex_rd != REG_ZERO) && (ex_rd == src)) begin
      sel = FWD_EX_MEM;
    end else if (wb_we && (wb_rd != REG_ZERO) && (wb_rd == src)) begin
      sel = FWD_MEM_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Combinational EX-stage operand forwarding: picks register file, EX_MEM or
// MEM_WB as the source of each ALU operand.
module forwarding_unit
  import mips_ctrl_pkg::*;
(
  input  logic       ex_mem_reg_write_i,
  input  logic [4:0] ex_mem_rd_i,
  input  logic       mem_wb_reg_write_i,
  input  logic [4:0] mem_wb_rd_i,
  input  logic [4:0] id_ex_rs_i,
  input  logic [4:0] id_ex_rt_i,
  output logic [1:0] forward_a_o,
  output logic [1:0] forward_b_o
);

  always_comb begin
    forward_a_o = fwd_select(ex_mem_reg_write_i, ex_mem_rd_i,
                             mem_wb_reg_write_i, mem_wb_rd_i, id_ex_rs_i);
    forward_b_o = fwd_select(ex_mem_reg_write_i, ex_mem_rd_i,
                             mem_wb_reg_write_i, mem_wb_rd_i, id_ex_rt_i);
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central sequencing for the 5-stage MIPS pipeline: stall/flush enables,
// I-cache miss refill handshake, operand forwarding and saturating perf counters.
module pipeline_hazard_controller
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int MISS_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit,
  input  logic             PCSrc,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_ex_MemRead,
  input  logic [4:0]       id_ex_rs,
  input  logic [4:0]       id_ex_rt,
  input  logic             ex_mem_RegWrite,
  input  logic [4:0]       ex_mem_rd,
  input  logic             mem_wb_RegWrite,
  input  logic [4:0]       mem_wb_rd,
  input  logic             mem_ack,
  input  logic             mem_valid,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_flush,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             mem_req,
  output logic             fill_en,
  output logic             miss_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Timer counts completed MISS_WAIT cycles, so it never needs to hold MISS_TIMEOUT itself.
  localparam int TMR_W = (MISS_TIMEOUT < 2) ? 1 : $clog2(MISS_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MISS_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               miss_err_q, miss_err_d;
  logic               mem_req_q, fill_en_q;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic               load_use;
  logic               pc_write_c, if_id_write_c, if_id_flush_c;
  logic               id_ex_bubble_c, ex_mem_flush_c;
  logic               stall_inc, flush_inc;
  logic [1:0]         fwd_a, fwd_b;

  forwarding_unit u_fwd (
    .ex_mem_reg_write_i (ex_mem_RegWrite),
    .ex_mem_rd_i        (ex_mem_rd),
    .mem_wb_reg_write_i (mem_wb_RegWrite),
    .mem_wb_rd_i        (mem_wb_rd),
    .id_ex_rs_i         (id_ex_rs),
    .id_ex_rt_i         (id_ex_rt),
    .forward_a_o        (fwd_a),
    .forward_b_o        (fwd_b)
  );

  assign load_use = id_ex_MemRead && (id_ex_rt != REG_ZERO) &&
                    ((id_ex_rt == id_rs) || (id_ex_rt == id_rt));

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    miss_err_d     = miss_err_q;
    pc_write_c     = 1'b1;
    if_id_write_c  = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_bubble_c = 1'b0;
    ex_mem_flush_c = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;

    if (state_q != RUN) begin
      pc_write_c    = 1'b0;
      if_id_write_c = 1'b0;
      if_id_flush_c = 1'b1;
      stall_inc     = 1'b1;
    end

    case (state_q)
      RUN: begin
        if (!PCSrc) begin
          if (!hit) begin
            state_d       = MISS_REQ;
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            if_id_flush_c = 1'b1;
          end else if (load_use) begin
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            id_ex_bubble_c = 1'b1;
            stall_inc      = 1'b1;
          end
        end
      end
      MISS_REQ: begin
        if (mem_ack) begin
          state_d = MISS_WAIT;
          timer_d = '0;
        end
      end
      MISS_WAIT: begin
        if (mem_valid) begin
          state_d = REFILL;
        end else if (timer_q == TMR_LAST) begin
          state_d    = RUN;
          miss_err_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      REFILL: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // A taken branch overrides any stall but leaves an outstanding refill running.
    if (PCSrc) begin
      pc_write_c     = 1'b1;
      if_id_write_c  = 1'b1;
      if_id_flush_c  = 1'b1;
      id_ex_bubble_c = 1'b1;
      ex_mem_flush_c = 1'b1;
      flush_inc      = 1'b1;
      stall_inc      = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_inc && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      timer_q     <= '0;
      miss_err_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      fill_en_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      miss_err_q  <= miss_err_d;
      mem_req_q   <= (state_d == MISS_REQ);
      fill_en_q   <= (state_d == REFILL);
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Combinational enables are held inactive while reset is asserted.
  assign pc_write     = rst & pc_write_c;
  assign if_id_write  = rst & if_id_write_c;
  assign if_id_flush  = rst & if_id_flush_c;
  assign id_ex_bubble = rst & id_ex_bubble_c;
  assign ex_mem_flush = rst & ex_mem_flush_c;
  assign forward_a    = rst ? fwd_a : FWD_RF;
  assign forward_b    = rst ? fwd_b : FWD_RF;
  assign mem_req      = mem_req_q;
  assign fill_en      = fill_en_q;
  assign miss_err     = miss_err_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios plus
// randomized cycles checked against a behavioural model of the hazard rules.
module tb_pipeline_hazard_controller;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             hit, PCSrc;
  logic [4:0]       id_rs, id_rt;
  logic             id_ex_MemRead;
  logic [4:0]       id_ex_rs, id_ex_rt;
  logic             ex_mem_RegWrite;
  logic [4:0]       ex_mem_rd;
  logic             mem_wb_RegWrite;
  logic [4:0]       mem_wb_rd;
  logic             mem_ack, mem_valid;
  logic             pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush;
  logic [1:0]       forward_a, forward_b;
  logic             mem_req, fill_en, miss_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 fetching, 1 requesting line, 2 waiting for line, 3 writing line.
  int mPhase;
  int mWait;
  int mErr;
  int mStall;
  int mFlush;

  int reqHigh;
  int fillHigh;

  pipeline_hazard_controller #(.CNT_W(CNT_W), .MISS_TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .rst             (rst),
    .hit             (hit),
    .PCSrc           (PCSrc),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_ex_MemRead   (id_ex_MemRead),
    .id_ex_rs        (id_ex_rs),
    .id_ex_rt        (id_ex_rt),
    .ex_mem_RegWrite (ex_mem_RegWrite),
    .ex_mem_rd       (ex_mem_rd),
    .mem_wb_RegWrite (mem_wb_RegWrite),
    .mem_wb_rd       (mem_wb_rd),
    .mem_ack         (mem_ack),
    .mem_valid       (mem_valid),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_flush    (ex_mem_flush),
    .forward_a       (forward_a),
    .forward_b       (forward_b),
    .mem_req         (mem_req),
    .fill_en         (fill_en),
    .miss_err        (miss_err),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int expLoadUse();
    return (id_ex_MemRead && id_ex_rt != 0 && (id_ex_rt == id_rs || id_ex_rt == id_rt)) ? 1 : 0;
  endfunction

  function automatic logic [1:0] expFwd(input logic [4:0] src);
    if (ex_mem_RegWrite && ex_mem_rd != 0 && ex_mem_rd == src) return 2'b10;
    if (mem_wb_RegWrite && mem_wb_rd != 0 && mem_wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic resetModel();
    mPhase = 0;
    mWait  = 0;
    mErr   = 0;
    mStall = 0;
    mFlush = 0;
  endtask

  task automatic applyStimulus(input logic h, input logic br, input logic ack, input logic vld);
    hit       = h;
    PCSrc     = br;
    mem_ack   = ack;
    mem_valid = vld;
  endtask

  task automatic clearInputs();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    id_rs = 0; id_rt = 0; id_ex_MemRead = 0; id_ex_rs = 0; id_ex_rt = 0;
    ex_mem_RegWrite = 0; ex_mem_rd = 0; mem_wb_RegWrite = 0; mem_wb_rd = 0;
  endtask

  // Expected outputs for the current inputs and the model's current situation.
  task automatic checkCycle();
    logic expPcw, expIfw, expIff, expBub, expExf;
    expPcw = 1; expIfw = 1; expIff = 0; expBub = 0; expExf = 0;
    if (PCSrc) begin
      expIff = 1; expBub = 1; expExf = 1;
    end else if (mPhase != 0 || !hit) begin
      expPcw = 0; expIfw = 0; expIff = 1;
    end else if (expLoadUse() != 0) begin
      expPcw = 0; expIfw = 0; expBub = 1;
    end
    checkOutput("pc_write", pc_write, expPcw);
    checkOutput("if_id_write", if_id_write, expIfw);
    checkOutput("if_id_flush", if_id_flush, expIff);
    checkOutput("id_ex_bubble", id_ex_bubble, expBub);
    checkOutput("ex_mem_flush", ex_mem_flush, expExf);
    checkOutput("forward_a", forward_a, expFwd(id_ex_rs));
    checkOutput("forward_b", forward_b, expFwd(id_ex_rt));
    checkOutput("mem_req", mem_req, (mPhase == 1) ? 1 : 0);
    checkOutput("fill_en", fill_en, (mPhase == 3) ? 1 : 0);
    checkOutput("miss_err", miss_err, mErr);
    checkOutput("stall_cnt", stall_cnt, mStall);
    checkOutput("flush_cnt", flush_cnt, mFlush);
  endtask

  task automatic updateModel();
    if (PCSrc) mFlush = (mFlush < CNT_MAX) ? mFlush + 1 : CNT_MAX;
    else if (mPhase != 0 || (hit && expLoadUse() != 0)) mStall = (mStall < CNT_MAX) ? mStall + 1 : CNT_MAX;
    case (mPhase)
      0: if (!PCSrc && !hit) mPhase = 1;
      1: if (mem_ack) begin mPhase = 2; mWait = 0; end
      2: begin
        mWait++;
        if (mem_valid) mPhase = 3;
        else if (mWait == TIMEOUT) begin mPhase = 0; mErr = 1; end
      end
      default: mPhase = 0;
    endcase
  endtask

  // Entered and left at a falling edge; inputs must already be driven.
  task automatic stepCycle();
    #1;
    checkCycle();
    if (mem_req) reqHigh++;
    if (fill_en) fillHigh++;
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b0;
    resetModel();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    clearInputs();
    rst = 1'b0;
    resetModel();
    ex_mem_RegWrite = 1; ex_mem_rd = 3; id_ex_rs = 3;
    #3;
    checkOutput("rstPcWrite", pc_write, 0);
    checkOutput("rstIfIdWrite", if_id_write, 0);
    checkOutput("rstFwdA", forward_a, 0);
    checkOutput("rstMemReq", mem_req, 0);
    checkOutput("rstStall", stall_cnt, 0);
    clearInputs();
    doReset();

    // Load-use stall lasts exactly one cycle
    id_ex_MemRead = 1; id_ex_rt = 5; id_rs = 5;
    stepCycle();
    id_ex_MemRead = 0;
    stepCycle();
    checkOutput("loadUseStall", stall_cnt, 1);
    checkOutput("loadUseResume", pc_write, 1);

    // Forwarding priority and $zero exclusion
    clearInputs();
    ex_mem_RegWrite = 1; ex_mem_rd = 3; mem_wb_RegWrite = 1; mem_wb_rd = 3; id_ex_rs = 3; id_ex_rt = 3;
    stepCycle();
    checkOutput("fwdBothA", forward_a, 2'b10);
    ex_mem_rd = 0;
    stepCycle();
    checkOutput("fwdWbA", forward_a, 2'b01);
    checkOutput("fwdWbB", forward_b, 2'b01);

    // Miss: ack on third request cycle, line on fourth wait cycle
    clearInputs();
    doReset();
    reqHigh = 0; fillHigh = 0;
    applyStimulus(0, 0, 0, 0); stepCycle();
    applyStimulus(1, 0, 0, 0); stepCycle(); stepCycle();
    applyStimulus(1, 0, 1, 0); stepCycle();
    applyStimulus(1, 0, 0, 0); stepCycle(); stepCycle(); stepCycle();
    applyStimulus(1, 0, 0, 1); stepCycle();
    applyStimulus(1, 0, 0, 0); stepCycle();
    stepCycle();
    checkOutput("missReqCycles", reqHigh, 3);
    checkOutput("missFillPulses", fillHigh, 1);
    checkOutput("missStallCnt", stall_cnt, 8);
    checkOutput("missBackToRun", pc_write, 1);

    // Branch while waiting for the line: refill still completes
    doReset();
    applyStimulus(0, 0, 0, 0); stepCycle();
    applyStimulus(1, 0, 1, 0); stepCycle();
    applyStimulus(1, 1, 0, 0);
    #1;
    checkOutput("brWaitPcWrite", pc_write, 1);
    checkOutput("brWaitExFlush", ex_mem_flush, 1);
    stepCycle();
    applyStimulus(1, 0, 0, 1); stepCycle();
    checkOutput("brFlushCnt", flush_cnt, 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("brRefill", fill_en, 1);
    stepCycle();

    // Timeout with no line ever arriving
    doReset();
    applyStimulus(0, 0, 0, 0); stepCycle();
    applyStimulus(1, 0, 1, 0); stepCycle();
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < TIMEOUT; i++) stepCycle();
    checkOutput("timeoutErr", miss_err, 1);
    stepCycle();
    checkOutput("timeoutRun", pc_write, 1);
    checkOutput("timeoutStall", stall_cnt, 5);

    // Asynchronous reset in the middle of a request
    doReset();
    applyStimulus(0, 0, 0, 0); stepCycle();
    applyStimulus(1, 0, 0, 0); stepCycle();
    #2;
    checkOutput("preRstReq", mem_req, 1);
    rst = 1'b0;
    #1;
    checkOutput("midRstReq", mem_req, 0);
    checkOutput("midRstStall", stall_cnt, 0);
    checkOutput("midRstPcWrite", pc_write, 0);
    resetModel();
    @(negedge clk);
    rst = 1'b1;
    stepCycle();

    // Randomized traffic, long enough to saturate the narrow counters
    doReset();
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3));
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      id_ex_MemRead   = 1'($urandom_range(0, 1));
      id_ex_rs        = 5'($urandom_range(0, 3));
      id_ex_rt        = 5'($urandom_range(0, 3));
      ex_mem_RegWrite = 1'($urandom_range(0, 1));
      ex_mem_rd       = 5'($urandom_range(0, 3));
      mem_wb_RegWrite = 1'($urandom_range(0, 1));
      mem_wb_rd       = 5'($urandom_range(0, 3));
      stepCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central sequencing block for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Generates PC/IF_ID write enables, stage flushes/bubbles and EX operand-forwarding selects.
- Runs the I-cache miss refill handshake toward instruction memory (128-bit line).
- Keeps saturating stall/flush performance counters.
- Sits beside the pipeline registers; all pipe registers consume its enables.

Parameters:
- CNT_W, 16, width of each performance counter.
- MISS_TIMEOUT, 255, max cycles in MISS_WAIT before abort and error.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- hit  in  1  I-cache hit for the current fetch.
- PCSrc  in  1  branch taken, resolved in MEM.
- id_rs, id_rt  in  5 each  source registers of the instruction in IF_ID.
- id_ex_MemRead  in  1  load in EX.
- id_ex_rs, id_ex_rt  in  5 each  EX source registers.
- ex_mem_RegWrite  in  1  MEM-stage writes a register.
- ex_mem_rd  in  5  MEM-stage destination.
- mem_wb_RegWrite  in  1  WB-stage writes a register.
- mem_wb_rd  in  5  WB-stage destination.
- mem_ack  in  1  instruction memory accepted the line request.
- mem_valid  in  1  128-bit line present on mem_in.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF_ID load enable.
- if_id_flush  out  1  IF_ID loads a NOP.
- id_ex_bubble  out  1  ID_EX control bits forced to 0.
- ex_mem_flush  out  1  EX_MEM control bits forced to 0.
- forward_a, forward_b  out  2 each  ALU operand select: 00 register file, 10 EX_MEM, 01 MEM_WB.
- mem_req  out  1  line request, registered.
- fill_en  out  1  write line into I-cache, registered.
- miss_err  out  1  sticky timeout flag.
- stall_cnt, flush_cnt  out  CNT_W each  saturating counters.

Behaviour:
- Reset (rst=0, async): state=RUN; mem_req, fill_en, miss_err, counters=0; pc_write, if_id_write, flushes, bubble=0; forward selects=00.
- States: RUN, MISS_REQ, MISS_WAIT, REFILL.
- Priority each cycle: PCSrc > cache miss > load-use.
- Branch (PCSrc=1, any state): same cycle assert if_id_flush, id_ex_bubble, ex_mem_flush. pc_write=1 to load target. flush_cnt+1.
  - In MISS_* states the outstanding request is not cancelled; FSM continues and the line is still filled.
- Miss: RUN with hit=0 and PCSrc=0 gives next state MISS_REQ. pc_write=0, if_id_write=0, if_id_flush=1. Downstream stages keep advancing.
- MISS_REQ: mem_req=1 held until mem_ack=1, then MISS_WAIT with mem_req=0 next cycle. Timer clears on entry.
- MISS_WAIT: on mem_valid=1, go to REFILL. If timer reaches MISS_TIMEOUT with no mem_valid, set miss_err=1 (cleared only by reset) and return to RUN.
- REFILL: fill_en=1 for exactly one cycle, then RUN. Refetch occurs in RUN, where hit=1.
- In all MISS_* and REFILL cycles (no PCSrc): pc_write=0, if_id_write=0, if_id_flush=1. stall_cnt+1.
- Load-use (RUN, hit=1, no PCSrc): condition is id_ex_MemRead and id_ex_rt!=0 and (id_ex_rt==id_rs or id_ex_rt==id_rt).
  - Response: pc_write=0, if_id_write=0, id_ex_bubble=1. stall_cnt+1.
  - Self-clears next cycle, so the stall is exactly one cycle.
- Normal RUN: pc_write=1, if_id_write=1, flushes/bubble=0.
- Forwarding (combinational, every state): forward_a=10 if ex_mem_RegWrite and ex_mem_rd!=0 and ex_mem_rd==id_ex_rs.
  - Otherwise 01 if mem_wb_RegWrite and mem_wb_rd!=0 and mem_wb_rd==id_ex_rs.
  - Otherwise 00. forward_b uses the same rule with id_ex_rt.
  - EX_MEM wins when both stages match.
- Counters saturate at all-ones and do not wrap. A cycle counting both stall and flush increments only flush_cnt.

Decomposition:
- Package mips_ctrl_pkg: state enum (RUN, MISS_REQ, MISS_WAIT, REFILL), FWD_RF=00, FWD_MEM_WB=01, FWD_EX_MEM=10, REG_ZERO=5'd0.
- Sub-module forwarding_unit: pure combinational forward_a/forward_b logic, instantiated once.

Test Plan:
- Load-use: id_ex_MemRead=1, id_ex_rt=5, id_rs=5 -> one cycle pc_write=0, if_id_write=0, id_ex_bubble=1, then normal; stall_cnt=1.
- Forwarding: ex_mem_rd=3 and mem_wb_rd=3 (both RegWrite), id_ex_rs=3 -> forward_a=10. Same with ex_mem_rd=0 -> forward_a=01.
- Miss: hit=0, mem_ack after 2 cycles, mem_valid 4 cycles later -> mem_req high 3 cycles, fill_en one pulse, RUN after REFILL, stall_cnt=8.
- Branch during MISS_WAIT: PCSrc=1 -> all three flushes and pc_write=1 that cycle, flush_cnt=1; FSM still reaches REFILL when mem_valid arrives.
- Timeout: MISS_TIMEOUT=4, mem_valid never arrives -> miss_err=1 after 4 MISS_WAIT cycles, state RUN.
- Reset mid-miss: rst=0 in MISS_REQ -> mem_req=0 immediately (async), state RUN, counters 0.
